// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : APB master driving the ECC block's APB slave port. Read/write
//            commands arrive on a valid/ready interface and are buffered in a
//            small FIFO. Each command then runs as a two-phase APB transfer
//            (SETUP, ACCESS) with no wait states. Read data is returned on a
//            one-cycle response strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO not full (combinational from occupancy)
//   cmd_write  in   1 = write, 0 = read
//   cmd_addr   in   target APB address
//   cmd_wdata  in   write data (carried unchanged for reads)
//   rsp_valid  out  one-cycle pulse when a read completes
//   rsp_rdata  out  captured PRDATA, held until the next read completes
//   busy       out  FSM not idle or FIFO not empty
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  out  APB request
//   PRDATA     in   APB read data
// ============================================================================
module apb_cmd_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int CMD_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA
);

    localparam int c_ptr_w = $clog2(CMD_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(CMD_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [AMBA_ADDR_WIDTH-1:0] fifo_addr_q  [CMD_DEPTH];
    logic [AMBA_WORD-1:0]       fifo_wdata_q [CMD_DEPTH];
    logic [CMD_DEPTH-1:0]       fifo_write_q;
    logic [c_ptr_w-1:0]         wr_ptr_q;
    logic [c_ptr_w-1:0]         rd_ptr_q;
    logic [c_cnt_w-1:0]         count_q;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full    = (count_q == c_full_cnt);
    assign w_empty   = (count_q == '0);
    // Ready looks only at the current occupancy, so a full FIFO refuses a
    // push even in a cycle where the FSM pops.
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
            fifo_write_q[wr_ptr_q] <= cmd_write;
        end
    end

    // Pointers wrap naturally because CMD_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_cnt_one;
                2'b01:   count_q <= count_q - c_cnt_one;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Chain straight into the next SETUP so PSEL stays high.
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered APB and response outputs
    // ------------------------------------------------------------------
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
    logic                       psel_q;
    logic                       penable_q;
    logic                       pwrite_q;
    logic [AMBA_WORD-1:0]       pwdata_q;
    logic                       rsp_valid_q;
    logic [AMBA_WORD-1:0]       rsp_rdata_q;
    logic                       w_rd_done;

    // A read finishes on the edge that leaves ACCESS.
    assign w_rd_done = (state_q == ST_ACCESS) && !pwrite_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= (state_d != ST_IDLE);
            penable_q   <= (state_d == ST_ACCESS);
            if (w_pop) begin
                paddr_q  <= fifo_addr_q[rd_ptr_q];
                pwdata_q <= fifo_wdata_q[rd_ptr_q];
                pwrite_q <= fifo_write_q[rd_ptr_q];
            end
            rsp_valid_q <= w_rd_done;
            if (w_rd_done) begin
                rsp_rdata_q <= PRDATA;
            end
        end
    end

    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Purpose  : Self-checking bench for apb_cmd_master. A transaction-level model
//            tracks queued commands, the expected APB phase sequence and read
//            responses; directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;

    apb_cmd_master #(
        .AMBA_WORD       (DW),
        .AMBA_ADDR_WIDTH (AW),
        .CMD_DEPTH       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Slave read-data model
    // ------------------------------------------------------------------
    logic          use_ovr;
    logic [DW-1:0] ovr_data;

    function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
        return {a[7:0], a[19:8], 12'h0} ^ {12'h0, a} ^ 32'hA5C3_0F96;
    endfunction

    assign PRDATA = use_ovr ? ovr_data : hash(PADDR);

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model, evaluated mid-cycle on the falling edge
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t          model_q[$];
    cmd_t          push_c;
    cmd_t          cur;
    logic          push_pend;
    logic          prev_setup;     // previous cycle was expected to be SETUP
    logic          prev_nonempty;  // commands were waiting in the previous cycle
    logic          exp_sel;
    logic          exp_en;
    logic          exp_write;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          pend_rsp;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] last_rdata;
    int            run_len;
    int            last_run;
    logic [15:0]   pat;
    logic [15:0]   last_pat;
    logic          saw_nr;

    always @(negedge clk) begin
        if (!rst) begin
            model_q.delete();
            push_pend     = 1'b0;
            prev_setup    = 1'b0;
            prev_nonempty = 1'b0;
            exp_write     = 1'b0;
            exp_addr      = '0;
            exp_wdata     = '0;
            pend_rsp      = 1'b0;
            pend_data     = '0;
            last_rdata    = '0;
            run_len       = 0;
            pat           = '0;
        end else begin
            if (push_pend) begin
                model_q.push_back(push_c);
                push_pend = 1'b0;
            end

            // A SETUP is always followed by ACCESS; otherwise a new SETUP
            // starts exactly when a command was waiting.
            if (prev_setup) begin
                exp_sel = 1'b1;
                exp_en  = 1'b1;
            end else begin
                exp_sel = prev_nonempty;
                exp_en  = 1'b0;
            end
            check("psel", PSEL, exp_sel);
            check("penable", PENABLE, exp_en);

            if (exp_sel && !exp_en) begin
                if (model_q.size() == 0) begin
                    check("pop_empty", 1, 0);
                end else begin
                    cur       = model_q.pop_front();
                    exp_write = cur.w;
                    exp_addr  = cur.a;
                    exp_wdata = cur.d;
                end
            end
            check("paddr", PADDR, exp_addr);
            check("pwrite", PWRITE, exp_write);
            check("pwdata", PWDATA, exp_wdata);

            check("rsp_valid", rsp_valid, pend_rsp);
            if (pend_rsp) begin
                last_rdata = pend_data;
            end
            check("rsp_rdata", rsp_rdata, last_rdata);
            pend_rsp  = exp_sel && exp_en && !exp_write;
            pend_data = use_ovr ? ovr_data : hash(exp_addr);

            check("cmd_ready", cmd_ready, model_q.size() < 4);
            check("busy", busy, exp_sel || (model_q.size() != 0));
            if (!cmd_ready) saw_nr = 1'b1;

            if (PSEL) begin
                run_len++;
                pat = {pat[14:0], PENABLE};
            end else if (run_len != 0) begin
                last_run = run_len;
                last_pat = pat;
                run_len  = 0;
                pat      = '0;
            end

            prev_setup    = exp_sel && !exp_en;
            prev_nonempty = (model_q.size() != 0);
            if (cmd_valid && cmd_ready) begin
                push_pend = 1'b1;
                push_c    = '{w: cmd_write, a: cmd_addr, d: cmd_wdata};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 2)
    // ------------------------------------------------------------------
    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int tries;
        tries     = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && tries < 100) begin
            @(posedge clk);
            #2;
            tries++;
        end
        if (!cmd_ready) check("push_timeout", 0, 1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) check("idle_timeout", 1, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        use_ovr   = 1'b0;
        ovr_data  = '0;
        saw_nr    = 1'b0;
        last_run  = 0;
        last_pat  = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        check("rst_ready", cmd_ready, 1);
        @(posedge clk);
        #2;

        // Single write
        push_cmd(1'b1, 20'h00004, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("wr_e1_psel", PSEL, 1);
        check("wr_e1_pen", PENABLE, 0);
        check("wr_e1_pwrite", PWRITE, 1);
        check("wr_e1_paddr", PADDR, 20'h00004);
        check("wr_e1_pwdata", PWDATA, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("wr_e2_pen", PENABLE, 1);
        @(posedge clk); #1;
        check("wr_e3_psel", PSEL, 0);
        check("wr_e3_rsp", rsp_valid, 0);
        #1;

        // Single read with a fixed slave value
        use_ovr  = 1'b1;
        ovr_data = 32'h12345678;
        push_cmd(1'b0, 20'h00010, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        @(posedge clk); #1;
        check("rd_rsp_pulse", rsp_valid, 0);
        check("rd_rsp_hold", rsp_rdata, 32'h12345678);
        #1;
        use_ovr = 1'b0;
        wait_idle();

        // Back-to-back writes
        push_cmd(1'b1, 20'h00000, 32'h1111_0000);
        push_cmd(1'b1, 20'h00004, 32'h2222_0004);
        push_cmd(1'b1, 20'h00008, 32'h3333_0008);
        wait_idle();
        check("b2b_run", last_run, 6);
        check("b2b_pen", last_pat, 16'b010101);

        // Backpressure: producer outruns the two-cycle transfers
        saw_nr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'b0, AW'(32'h100 + 4 * i), $urandom);
        end
        check("bp_not_ready", saw_nr, 1);
        wait_idle();

        // Reset during ACCESS of a read with two commands queued
        push_cmd(1'b0, 20'h00200, 32'h0);
        push_cmd(1'b0, 20'h00204, 32'h0);
        push_cmd(1'b0, 20'h00208, 32'h0);
        check("rst_pre_pen", PENABLE, 1);
        check("rst_pre_pwrite", PWRITE, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_psel", PSEL, 0);
        check("rst_mid_pen", PENABLE, 0);
        check("rst_mid_rsp", rsp_valid, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        check("rst_post_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("rst_post_psel", PSEL, 0);
        check("rst_post_busy2", busy, 0);
        @(posedge clk);
        #2;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_write = $urandom_range(0, 1) == 1;
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        check("drain_empty", model_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
